// File: rtl/mem_access_stage.sv
// MEM stage: drives the variable-latency data-memory port, stalls upstream, registers MEM/WB.
// Define MEM_ALIGN_CHECK_EN to reject word-misaligned accesses with a bus error.
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] MemWdata_i,
  input  logic [4:0]  RegWaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUdata_o,
  output logic [31:0] MemRdata_o,
  output logic [4:0]  RegWaddr_o,
  output logic        bus_err_o
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdat_q, rdat_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        err_q, err_d;

  logic access, is_rd, mis, go;
  logic timeout_hit, req, stall;

  always_comb begin
    access = MemRead_i | MemWrite_i;
    is_rd  = MemRead_i & ~MemWrite_i;
`ifdef MEM_ALIGN_CHECK_EN
    mis = access & (|ALUdata_i[1:0]);
`else
    mis = 1'b0;
`endif
    go = access & ~mis;
    timeout_hit = (state_q == S_WAIT)
                & (cnt_q == CNT_W'(TIMEOUT_CYC - 1))
                & ~mem_ack_i;

    state_d = state_q;
    cnt_d   = '0;
    req     = 1'b0;
    stall   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req   = go;
        stall = go & ~mem_ack_i;
        if (stall) state_d = S_WAIT;
      end
      S_WAIT: begin
        req   = 1'b1;
        stall = ~mem_ack_i & ~timeout_hit;
        if (stall) cnt_d = cnt_q + CNT_W'(1);
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion (not stalled) loads MEM/WB; a stall loads a bubble
    rw_d    = 1'b0;
    m2r_d   = 1'b0;
    alu_d   = alu_q;
    rdat_d  = rdat_q;
    waddr_d = waddr_q;
    if (!stall) begin
      rw_d    = RegWrite_i & ~timeout_hit & ~(mis & is_rd);
      m2r_d   = MemtoReg_i;
      alu_d   = ALUdata_i;
      waddr_d = RegWaddr_i;
      rdat_d  = (is_rd & go & mem_ack_i) ? mem_rdata_i : 32'h0;
    end
    err_d = err_q | timeout_hit | mis;

    if (rst_i) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      alu_q   <= 32'h0;
      rdat_q  <= 32'h0;
      waddr_q <= 5'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      rdat_q  <= rdat_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = req;
  assign mem_we_o    = MemWrite_i;
  assign mem_addr_o  = ALUdata_i;
  assign mem_wdata_o = MemWdata_i;
  assign stall_o     = stall;
  assign RegWrite_o  = rw_q;
  assign MemtoReg_o  = m2r_q;
  assign ALUdata_o   = alu_q;
  assign MemRdata_o  = rdat_q;
  assign RegWaddr_o  = waddr_q;
  assign bus_err_o   = err_q;

endmodule
